i2c_target: RTL and testbench
=============================

Name: i2c_target

Overview:
- Write-only I2C target (responder) for the same bus the on-chip I2C master drives.
- Receives transactions of the form START, {device7, R/W}, ACK, reg address, ACK, data bytes each followed by ACK, then STOP.
- Emits one single-cycle register-write strobe per data byte; the register address auto-increments after each byte.
- Used to let an external controller, or a loopback test against the master, program on-chip registers.

Parameters:
- DEVICE, 7'h3C, 7-bit target address; matched against bits [7:1] of the first byte after START.
- SYNC_STAGES, 2, number of synchronizer flops on SCL and SDA (minimum 2).

Ports:
- clk  input  1  system clock, at least 16x the SCL frequency.
- reset  input  1  asynchronous, active-low reset.
- scl  inout  1  I2C clock; this block only samples it and never drives it (no clock stretching).
- sda  inout  1  I2C data; open-drain, driven only as 1'b0 or 1'bz.
- wr_valid  output  1  one-cycle strobe: a data byte was received.
- wr_addr  output  8  register address for the current strobe.
- wr_data  output  8  data byte for the current strobe.
- busy  output  1  high from an address-matched START until STOP or a mismatch.

Behaviour:
- Reset (reset=0, asynchronous):
  - sda released (z); wr_valid=0, wr_addr=0, wr_data=0, busy=0.
  - State IDLE; synchronizers preset to 1 (idle bus).
- Input path:
  - scl and sda pass through SYNC_STAGES flops, plus one registered copy for edge detection.
  - All bus events below use the synchronized values.
- Bus events:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - rise/fall: SCL edges.
  - START or STOP is recognised in every state, including mid-byte and during ACK.
  - START (including repeated START) -> DEV, bit counter=0, sda released.
  - STOP -> IDLE, sda released, busy=0.
- Bit reception: on each SCL rise, shift the synchronized SDA into an 8-bit shift register, MSB first. The bit counter runs 0..7.
- ACK generation:
  - On the SCL fall after the 8th bit, drive sda=0 if ACKing; otherwise leave it z.
  - Hold through the 9th SCL pulse; release on the following SCL fall.
- States:
  - IDLE: wait for START.
  - DEV: after 8 bits:
    - byte[7:1]==DEVICE and byte[0]==0 -> DEV_ACK, busy=1.
    - otherwise (mismatch, or a read request) -> IGNORE, no ACK.
  - DEV_ACK -> REG after the release fall.
  - REG: after 8 bits, latch the byte into the address register -> REG_ACK (ACK).
  - REG_ACK -> DATA.
  - DATA: after 8 bits -> DATA_ACK (ACK).
    - On the cycle the 8th bit is sampled: wr_valid=1 for exactly one clk, wr_data=byte, wr_addr=current address.
    - Next cycle: address += 1, wrapping 8'hFF -> 8'h00.
  - DATA_ACK -> DATA (further bytes continue).
  - IGNORE: sda stays z; leave only on START or STOP.
- Latency: wr_valid asserts SYNC_STAGES+1 clk cycles after the 8th SCL rising edge of a data byte at the pin.
- wr_addr and wr_data hold their values until the next strobe.
- No backpressure: the downstream block must accept a write every cycle wr_valid is high.
- A STOP or START before a data byte completes discards the partial byte: no strobe, no address increment.
- sda is never driven during START/STOP detection windows or while SCL is high outside an ACK slot.

Decomposition:
- Shared package `i2c_pkg`:
  - State enum (IDLE, DEV, DEV_ACK, REG, REG_ACK, DATA, DATA_ACK, IGNORE).
  - Constant I2C_RW_WRITE=1'b0.
  - Default target address constant.
- One sub-module `i2c_sync_edge`: N-flop synchronizer with a registered previous value; outputs level, rise and fall. Instantiated for scl and sda; START/STOP derived in the parent.

Test Plan:
- Back-to-back with the existing I2C master (device=8'h78, addr=8'h10, data=8'hA5):
  - ACK observed on all three 9th clocks.
  - Exactly one wr_valid with wr_addr=8'h10, wr_data=8'hA5; busy drops after STOP.
- Bus model write of 0x78, 0x20, then data 0x11, 0x22, 0x33 -> three strobes at addr 0x20/0x21/0x22 with the matching data; no strobe before the first data byte.
- Device byte 8'h7A (wrong address), then 0x10, 0x55 -> sda never driven low, no wr_valid, busy stays 0; a later valid transaction still works.
- Device byte 8'h79 (read request) -> NACK, state IGNORE, no strobes until STOP.
- Reg 8'hFF, then data 0xAA, 0xBB -> strobes at 0xFF then 0x00.
- Repeated START after 4 bits of a data byte, then 0x78, 0x05, 0x66 -> partial byte dropped, single strobe at 0x05 with data 0x66.
- Assert reset mid-ACK -> sda released immediately; wr_valid=0, busy=0 without waiting for clk.

Source files
------------

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared types and constants for the write-only I2C target
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DEV,
        DEV_ACK,
        REG,
        REG_ACK,
        DATA,
        DATA_ACK,
        IGNORE
    } i2c_state_t;

    localparam logic       I2C_RW_WRITE       = 1'b0;
    localparam logic [6:0] I2C_DEFAULT_DEVICE = 7'h3C;

    // Receive state that follows each ACK slot once SDA is released.
    function automatic i2c_state_t ack_next(input i2c_state_t s);
        case (s)
            DEV_ACK: return REG;
            default: return DATA;
        endcase
    endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// rtl/i2c_sync_edge.sv - multi-flop synchronizer with level, rise and fall outputs
module i2c_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Preset high so a reset never looks like a bus START or STOP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - write-only I2C target producing one register-write strobe per data byte
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEVICE      = I2C_DEFAULT_DEVICE,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    inout  wire        scl,
    inout  wire        sda,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl_sync (
        .clk     (clk),
        .rst_n   (reset),
        .d_i     (scl),
        .level_o (scl_lvl),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda_sync (
        .clk     (clk),
        .rst_n   (reset),
        .d_i     (sda),
        .level_o (sda_lvl),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    logic bus_start, bus_stop;
    assign bus_start = sda_fall & scl_lvl;
    assign bus_stop  = sda_rise & scl_lvl;

    i2c_state_t state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       wr_valid_q, wr_valid_d;
    logic       busy_q, busy_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] byte_in;

    assign byte_in = {shift_q[6:0], sda_lvl};

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        addr_d     = addr_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_valid_d = 1'b0;
        busy_d     = busy_q;
        sda_oe_d   = sda_oe_q;

        if (wr_valid_q) begin
            addr_d = addr_q + 8'd1;
        end

        if (bus_stop) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (bus_start) begin
            state_d   = DEV;
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b0;
        end else begin
            case (state_q)
                DEV, REG, DATA: begin
                    if (scl_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (state_q == DEV) begin
                                if (byte_in[7:1] == DEVICE && byte_in[0] == I2C_RW_WRITE) begin
                                    state_d = DEV_ACK;
                                    busy_d  = 1'b1;
                                end else begin
                                    state_d = IGNORE;
                                    busy_d  = 1'b0;
                                end
                            end else if (state_q == REG) begin
                                addr_d  = byte_in;
                                state_d = REG_ACK;
                            end else begin
                                wr_valid_d = 1'b1;
                                wr_data_d  = byte_in;
                                wr_addr_d  = addr_q;
                                state_d    = DATA_ACK;
                            end
                        end
                    end
                end
                // First SCL fall drives the ACK, the one after the 9th pulse releases it.
                DEV_ACK, REG_ACK, DATA_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = ack_next(state_q);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'd0;
            addr_q     <= 8'd0;
            wr_addr_q  <= 8'd0;
            wr_data_q  <= 8'd0;
            wr_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            sda_oe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            addr_q     <= addr_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_valid_q <= wr_valid_d;
            busy_q     <= busy_d;
            sda_oe_q   <= sda_oe_d;
        end
    end

    assign sda      = sda_oe_q ? 1'b0 : 1'bz;
    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - bus-model testbench for i2c_target with a transaction-level reference
module tb_i2c_target;

    localparam time T = 60ns;

    logic clk = 1'b0;
    always #5ns clk = ~clk;

    logic       reset;
    logic       scl_drv;
    logic       tb_sda_low;
    wire        scl;
    wire        sda;
    logic       wr_valid;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    assign scl = scl_drv;
    assign sda = tb_sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_target dut (
        .clk      (clk),
        .reset    (reset),
        .scl      (scl),
        .sda      (sda),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy)
    );

    int          checks = 0;
    int          fails  = 0;
    int          dut_low_cnt = 0;
    logic [15:0] obs_q[$];
    logic [15:0] exp_q[$];
    logic [7:0]  tx_q[$];

    always @(negedge clk) begin
        if (wr_valid === 1'b1) obs_q.push_back({wr_addr, wr_data});
        if (!tb_sda_low && sda === 1'b0) dut_low_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_start();
        tb_sda_low = 1'b0; #T;
        scl_drv = 1'b1;    #T;
        tb_sda_low = 1'b1; #T;
        scl_drv = 1'b0;    #T;
    endtask

    task automatic bus_stop();
        tb_sda_low = 1'b1; #T;
        scl_drv = 1'b1;    #T;
        tb_sda_low = 1'b0; #T;
    endtask

    task automatic bus_bit(input logic b);
        tb_sda_low = ~b; #T;
        scl_drv = 1'b1;  #(2*T);
        scl_drv = 1'b0;  #T;
    endtask

    task automatic bus_ack(output logic ack);
        tb_sda_low = 1'b0; #T;
        scl_drv = 1'b1;    #T;
        ack = (sda === 1'b0);
        #T;
        scl_drv = 1'b0;    #T;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) bus_bit(b[i]);
        bus_ack(ack);
    endtask

    // Reference: a write to our address ACKs every byte; data bytes land at reg, reg+1, ... mod 256.
    task automatic do_txn(input bit with_stop);
        logic       match;
        logic       ack;
        logic [7:0] a;
        logic [7:0] dev;
        dev   = tx_q[0];
        match = (dev[7:1] == 7'h3C) && (dev[0] == 1'b0);
        a     = (tx_q.size() > 1) ? tx_q[1] : 8'h00;
        bus_start();
        for (int i = 0; i < tx_q.size(); i++) begin
            send_byte(tx_q[i], ack);
            chk($sformatf("ack_byte%0d", i), ack, match);
            if (i == 0) chk("busy_after_dev", busy, match);
            if (i == 1) chk("no_early_strobe", obs_q.size(), 0);
            if (i >= 2 && match) begin
                exp_q.push_back({a, tx_q[i]});
                a = a + 8'd1;
            end
        end
        if (with_stop) begin
            bus_stop();
            #(4*T);
            chk("busy_after_stop", busy, 1'b0);
        end
    endtask

    task automatic check_writes(input string tag);
        #(4*T);
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int low_before;
        reset = 1'b0;
        scl_drv = 1'b1;
        tb_sda_low = 1'b0;
        #22ns;
        chk("rst_sda", sda, 1'b1);
        chk("rst_wr_valid", wr_valid, 1'b0);
        chk("rst_wr_addr", wr_addr, 8'h00);
        chk("rst_wr_data", wr_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        reset = 1'b1;
        #(4*T);

        tx_q = '{8'h78, 8'h10, 8'hA5};
        do_txn(1'b1);
        check_writes("single");

        tx_q = '{8'h78, 8'h20, 8'h11, 8'h22, 8'h33};
        do_txn(1'b1);
        check_writes("burst");

        low_before = dut_low_cnt;
        tx_q = '{8'h7A, 8'h10, 8'h55};
        do_txn(1'b1);
        chk("wrong_addr_never_low", dut_low_cnt, low_before);
        check_writes("wrong_addr");

        tx_q = '{8'h78, 8'h30, 8'h01};
        do_txn(1'b1);
        check_writes("after_wrong");

        low_before = dut_low_cnt;
        tx_q = '{8'h79, 8'h10, 8'h55};
        do_txn(1'b1);
        chk("read_never_low", dut_low_cnt, low_before);
        check_writes("read_req");

        tx_q = '{8'h78, 8'hFF, 8'hAA, 8'hBB};
        do_txn(1'b1);
        check_writes("wrap");

        tx_q = '{8'h78, 8'h30};
        do_txn(1'b0);
        for (int i = 0; i < 4; i++) bus_bit(i[0]);
        tx_q = '{8'h78, 8'h05, 8'h66};
        do_txn(1'b1);
        check_writes("rep_start");

        bus_start();
        for (int i = 7; i >= 0; i--) bus_bit(i == 0 ? 1'b0 : (8'h78 >> i) & 1'b1);
        tb_sda_low = 1'b0;
        #T;
        chk("mid_ack_sda_low", sda, 1'b0);
        chk("mid_ack_busy", busy, 1'b1);
        reset = 1'b0;
        #1ns;
        chk("async_rst_sda", sda, 1'b1);
        chk("async_rst_wr_valid", wr_valid, 1'b0);
        chk("async_rst_busy", busy, 1'b0);
        scl_drv = 1'b1;
        #T;
        reset = 1'b1;
        #(4*T);
        obs_q.delete();

        for (int k = 0; k < 6; k++) begin
            int n;
            tx_q.delete();
            tx_q.push_back(($urandom_range(0, 2) != 0) ? 8'h78 : 8'($urandom));
            tx_q.push_back(8'($urandom));
            n = $urandom_range(0, 3);
            for (int j = 0; j < n; j++) tx_q.push_back(8'($urandom));
            do_txn(1'b1);
            check_writes($sformatf("rand%0d", k));
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
